// File: rtl/bm_mem_pkg.sv
// Shared types and defaults for the banked shift-state memory address generator.
// Holds the FSM state encoding and the default bus widths.
package bm_mem_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned CNT_WIDTH      = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      RESP    = 2'd3
   } state_t;

endpackage

// File: rtl/rd_timeout_counter.sv
// Read-data wait counter: cleared outside the wait window, counts waiting cycles,
// and flags when the configured limit is reached. It never wraps past the limit.
module rd_timeout_counter
   import bm_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_hit
);

   localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT);

   logic [CNT_WIDTH-1:0] r_count;

   // Wait-cycle counter, held at the limit so it cannot wrap
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LIMIT)) begin
         r_count <= r_count + 8'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_hit = (r_count == LIMIT);

endmodule

// File: rtl/shift_addr_gen.sv
// Single-outstanding memory command generator that prefixes each logical address
// with a bank bit taken from the upstream shift-state selects at accept time.
module shift_addr_gen
   import bm_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  single_clk,
   input  logic                  reset_n,
   input  logic                  write_shift_enabler,
   input  logic                  read_shift_enabler,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_write,
   output logic [ADDR_WIDTH:0]   mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  timeout_err
);

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_write;
   logic                  r_bank;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_timeout_err;
   logic                  w_accept;
   logic                  w_cnt_clear;
   logic                  w_cnt_en;
   logic                  w_hit;

   assign w_accept = req_valid && req_ready;

   rd_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_rd_timeout_counter (
      .i_clk    (single_clk),
      .i_rst_n  (reset_n),
      .i_clear  (w_cnt_clear),
      .i_enable (w_cnt_en),
      .o_hit    (w_hit)
   );

   // State register
   always_ff @(posedge single_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; a data strobe beats a timeout hit in the same cycle
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_state = ISSUE;
            end else begin
               w_next_state = IDLE;
            end
         end
         ISSUE: begin
            if (!mem_ready) begin
               w_next_state = ISSUE;
            end else if (r_write) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (mem_rvalid || w_hit) begin
               w_next_state = RESP;
            end else begin
               w_next_state = WAIT_RD;
            end
         end
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State-decoded outputs and counter controls
   always_comb begin
      req_ready   = 1'b0;
      mem_valid   = 1'b0;
      rsp_valid   = 1'b0;
      w_cnt_clear = 1'b1;
      w_cnt_en    = 1'b0;
      case (r_state)
         IDLE:  req_ready = 1'b1;
         ISSUE: mem_valid = 1'b1;
         WAIT_RD: begin
            w_cnt_clear = 1'b0;
            w_cnt_en    = !mem_rvalid;
         end
         RESP:    rsp_valid = 1'b1;
         default: req_ready = 1'b0;
      endcase
   end

   // Command capture; the bank bit is frozen here so later select changes are ignored
   always_ff @(posedge single_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_write <= 1'b0;
         r_bank  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_write <= req_write;
         r_bank  <= req_write ? write_shift_enabler : read_shift_enabler;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
      end else begin
         r_write <= r_write;
         r_bank  <= r_bank;
         r_addr  <= r_addr;
         r_wdata <= r_wdata;
      end
   end

   // Read response capture and sticky timeout flag
   always_ff @(posedge single_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_data    <= '0;
         r_timeout_err <= 1'b0;
      end else if ((r_state == WAIT_RD) && mem_rvalid) begin
         r_rsp_data    <= mem_rdata;
         r_timeout_err <= r_timeout_err;
      end else if ((r_state == WAIT_RD) && w_hit) begin
         r_rsp_data    <= '0;
         r_timeout_err <= 1'b1;
      end else begin
         r_rsp_data    <= r_rsp_data;
         r_timeout_err <= r_timeout_err;
      end
   end

   assign mem_write   = r_write;
   assign mem_addr    = {r_bank, r_addr};
   assign mem_wdata   = r_wdata;
   assign rsp_data    = r_rsp_data;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_shift_addr_gen.sv
// Self-checking bench for shift_addr_gen: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_shift_addr_gen;

   localparam int AW = 5;
   localparam int DW = 16;
   localparam int TO = 15;

   logic          single_clk = 1'b0;
   logic          reset_n;
   logic          write_shift_enabler;
   logic          read_shift_enabler;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          mem_valid;
   logic          mem_ready;
   logic          mem_write;
   logic [AW:0]   mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          timeout_err;

   int n_cmp = 0;
   int n_bad = 0;

   shift_addr_gen #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .single_clk          (single_clk),
      .reset_n             (reset_n),
      .write_shift_enabler (write_shift_enabler),
      .read_shift_enabler  (read_shift_enabler),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_write           (req_write),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .mem_valid           (mem_valid),
      .mem_ready           (mem_ready),
      .mem_write           (mem_write),
      .mem_addr            (mem_addr),
      .mem_wdata           (mem_wdata),
      .mem_rvalid          (mem_rvalid),
      .mem_rdata           (mem_rdata),
      .rsp_valid           (rsp_valid),
      .rsp_data            (rsp_data),
      .timeout_err         (timeout_err)
   );

   always #5 single_clk = ~single_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          wen;
      logic          ren;
      int            rdelay;    // WAIT_RD cycle index carrying mem_rvalid, 255 = never
      logic [DW-1:0] rdata;
      logic [AW:0]   exp_addr;
      logic [DW-1:0] exp_rsp;
      int            exp_lat;   // negedges from handshake to rsp_valid
      logic          exp_terr;
   } vec_t;

   vec_t vecs[7];

   task automatic idle_inputs();
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      write_shift_enabler = 1'b0;
      read_shift_enabler  = 1'b0;
   endtask

   task automatic do_txn(input vec_t v);
      int lat;
      @(negedge single_clk);
      chk("vec_req_ready_idle", req_ready, 32'd1);
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      write_shift_enabler = v.wen;
      read_shift_enabler  = v.ren;
      mem_ready = 1'b0;
      @(negedge single_clk);
      req_valid = 1'b0;
      write_shift_enabler = ~v.wen;
      read_shift_enabler  = ~v.ren;
      chk("vec_mem_valid", mem_valid, 32'd1);
      chk("vec_req_ready_busy", req_ready, 32'd0);
      chk("vec_mem_addr", mem_addr, v.exp_addr);
      chk("vec_mem_write", mem_write, v.wr);
      if (v.wr) chk("vec_mem_wdata", mem_wdata, v.wdata);
      mem_ready = 1'b1;
      @(negedge single_clk);
      mem_ready = 1'b0;
      chk("vec_mem_valid_drop", mem_valid, 32'd0);
      if (v.wr) begin
         chk("vec_wr_back_idle", req_ready, 32'd1);
      end else begin
         lat = -1;
         for (int k = 0; k < 40; k++) begin
            if (rsp_valid) begin
               lat = k;
               break;
            end
            mem_rvalid = (k == v.rdelay);
            mem_rdata  = mem_rvalid ? v.rdata : 16'hDEAD;
            @(negedge single_clk);
            mem_rvalid = 1'b0;
         end
         chk("vec_rsp_latency", lat, v.exp_lat);
         chk("vec_rsp_data", rsp_data, v.exp_rsp);
         @(negedge single_clk);
         chk("vec_rsp_one_cycle", rsp_valid, 32'd0);
         chk("vec_rd_back_idle", req_ready, 32'd1);
         chk("vec_rsp_data_hold", rsp_data, v.exp_rsp);
      end
      chk("vec_timeout_err", timeout_err, v.exp_terr);
   endtask

   // transaction-level reference model state for the random phase
   logic          m_busy, m_issued, m_waiting, m_rsp_due, m_terr, m_wr;
   logic [AW:0]   m_addr;
   logic [DW-1:0] m_wd, m_rd, m_rsp;
   int            m_idx, m_delay;

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      #1;
      chk("rst_mem_valid", mem_valid, 32'd0);
      chk("rst_rsp_valid", rsp_valid, 32'd0);
      repeat (2) @(negedge single_clk);
      reset_n = 1'b1;
      @(negedge single_clk);
      chk("rst_req_ready", req_ready, 32'd1);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_timeout_err", timeout_err, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);

      vecs[0] = '{1'b1, 5'h03, 16'hABCD, 1'b1, 1'b0, 255, 16'h0000, 6'h23, 16'h0000, 0,  1'b0};
      vecs[1] = '{1'b0, 5'h1F, 16'h0000, 1'b1, 1'b0, 3,   16'h1234, 6'h1F, 16'h1234, 4,  1'b0};
      vecs[2] = '{1'b0, 5'h0A, 16'h0000, 1'b0, 1'b1, 0,   16'hBEEF, 6'h2A, 16'hBEEF, 1,  1'b0};
      vecs[3] = '{1'b0, 5'h11, 16'h0000, 1'b0, 1'b1, 15,  16'h5A5A, 6'h31, 16'h5A5A, 16, 1'b0};
      vecs[4] = '{1'b0, 5'h04, 16'h0000, 1'b1, 1'b0, 255, 16'h0000, 6'h04, 16'h0000, 16, 1'b1};
      vecs[5] = '{1'b1, 5'h1E, 16'h0F0F, 1'b0, 1'b1, 255, 16'h0000, 6'h1E, 16'h0000, 0,  1'b1};
      vecs[6] = '{1'b0, 5'h07, 16'h0000, 1'b0, 1'b1, 1,   16'hC3C3, 6'h27, 16'hC3C3, 2,  1'b1};
      for (int i = 0; i < 7; i++) do_txn(vecs[i]);

      // bank bit frozen while the command stalls
      @(negedge single_clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h09; req_wdata = 16'h1111;
      write_shift_enabler = 1'b0; mem_ready = 1'b0;
      @(negedge single_clk);
      req_valid = 1'b0;
      write_shift_enabler = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("freeze_mem_valid", mem_valid, 32'd1);
         chk("freeze_mem_addr", mem_addr, 32'h09);
         @(negedge single_clk);
      end
      mem_ready = 1'b1;
      @(negedge single_clk);
      mem_ready = 1'b0;
      chk("freeze_done", mem_valid, 32'd0);

      // reset during WAIT_RD aborts the read and clears the sticky flag
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h02;
      @(negedge single_clk);
      req_valid = 1'b0; mem_ready = 1'b1;
      @(negedge single_clk);
      mem_ready = 1'b0;
      repeat (3) @(negedge single_clk);
      reset_n = 1'b0;
      #1;
      chk("abort_rsp_valid", rsp_valid, 32'd0);
      chk("abort_mem_valid", mem_valid, 32'd0);
      chk("abort_timeout_err", timeout_err, 32'd0);
      chk("abort_rsp_data", rsp_data, 32'd0);
      @(negedge single_clk);
      reset_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 16'h7777;
      for (int k = 0; k < 5; k++) begin
         @(negedge single_clk);
         chk("abort_no_rsp", rsp_valid, 32'd0);
         chk("abort_req_ready", req_ready, 32'd1);
      end
      mem_rvalid = 1'b0;

      m_busy = 1'b0; m_issued = 1'b0; m_waiting = 1'b0; m_rsp_due = 1'b0; m_terr = 1'b0;
      m_wr = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0; m_rsp = '0; m_idx = 0; m_delay = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge single_clk);
         chk("rnd_req_ready", req_ready, !m_busy);
         chk("rnd_mem_valid", mem_valid, m_busy && !m_issued);
         if (m_busy && !m_issued) begin
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_write", mem_write, m_wr);
            if (m_wr) chk("rnd_mem_wdata", mem_wdata, m_wd);
         end
         chk("rnd_rsp_valid", rsp_valid, m_rsp_due);
         if (m_rsp_due) chk("rnd_rsp_data", rsp_data, m_rsp);
         chk("rnd_timeout_err", timeout_err, m_terr);

         req_valid = ($urandom_range(0, 9) < 7);
         req_write = 1'($urandom_range(0, 1));
         req_addr  = AW'($urandom);
         req_wdata = DW'($urandom);
         write_shift_enabler = 1'($urandom_range(0, 1));
         read_shift_enabler  = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 2) != 0);
         if (m_waiting) begin
            mem_rvalid = (m_idx == m_delay);
            mem_rdata  = mem_rvalid ? m_rd : DW'($urandom);
         end else begin
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = DW'($urandom);
         end

         if (m_rsp_due) begin
            m_rsp_due = 1'b0;
            m_busy    = 1'b0;
         end else if (m_waiting) begin
            if (m_idx == m_delay) begin
               m_rsp_due = 1'b1; m_rsp = m_rd; m_waiting = 1'b0;
            end else if (m_idx == TO) begin
               m_rsp_due = 1'b1; m_rsp = '0; m_terr = 1'b1; m_waiting = 1'b0;
            end else begin
               m_idx++;
            end
         end else if (m_busy && !m_issued) begin
            if (mem_ready) begin
               m_issued = 1'b1;
               if (m_wr) begin
                  m_busy = 1'b0;
               end else begin
                  m_waiting = 1'b1;
                  m_idx     = 0;
                  m_delay   = $urandom_range(0, TO + 6);
                  m_rd      = DW'($urandom);
               end
            end
         end else if (!m_busy && req_valid) begin
            m_busy   = 1'b1;
            m_issued = 1'b0;
            m_wr     = req_write;
            m_addr   = {(req_write ? write_shift_enabler : read_shift_enabler), req_addr};
            m_wd     = req_wdata;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_addr_gen.md
SHIFT_ADDR_GEN -- requirements
Module: shift_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, logical address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max wait cycles for read data; range 1..255.
REQ-004 single_clk  in  1  sole clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 write_shift_enabler  in  1  write bank select, from upstream shift-state register.
REQ-007 read_shift_enabler  in  1  read bank select, from upstream shift-state register.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-010 req_write  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_WIDTH  logical address.
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 mem_valid  out  1  memory command valid.
REQ-014 mem_ready  in  1  memory accepts command.
REQ-015 mem_write  out  1  command type.
REQ-016 mem_addr  out  ADDR_WIDTH+1  physical address, {bank, req_addr}.
REQ-017 mem_wdata  out  DATA_WIDTH  command write data.
REQ-018 mem_rvalid  in  1  read data strobe.
REQ-019 mem_rdata  in  DATA_WIDTH  read data.
REQ-020 rsp_valid  out  1  one-cycle read-response pulse.
REQ-021 rsp_data  out  DATA_WIDTH  read response data.
REQ-022 timeout_err  out  1  sticky read-timeout flag.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT_RD, RESP.
REQ-024 req_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-025 On accept in IDLE: latch req_write, req_addr, req_wdata, and bank = req_write ? write_shift_enabler : read_shift_enabler; go to ISSUE.
REQ-026 Bank bit SHALL be frozen at accept; enabler changes afterwards do not affect the in-flight command.
REQ-027 ISSUE: mem_valid = 1 and mem_write/mem_addr/mem_wdata held stable until mem_ready; mem_addr = {bank, latched addr}.
REQ-028 ISSUE with mem_ready: write -> IDLE; read -> WAIT_RD, with timeout counter cleared to 0.
REQ-029 WAIT_RD: on mem_rvalid, capture mem_rdata into rsp_data and go to RESP; otherwise counter increments by 1.
REQ-030 WAIT_RD: counter == TIMEOUT with no mem_rvalid -> set timeout_err, rsp_data = 0, go to RESP. mem_rvalid in that same cycle wins and timeout_err is not set.
REQ-031 RESP: rsp_valid = 1 for exactly one cycle, then IDLE; rsp_data holds its value until the next capture.
REQ-032 mem_rvalid outside WAIT_RD SHALL be ignored.
REQ-033 timeout_err SHALL clear only on reset.
REQ-034 Minimum latency: write accept -> mem_valid next cycle; read accept -> rsp_valid 1 cycle after mem_rvalid.
REQ-035 Counter SHALL be 8 bits and never wrap; it saturates by leaving WAIT_RD.

Reset
REQ-036 reset_n low SHALL immediately force state IDLE, mem_valid = 0, rsp_valid = 0, rsp_data = 0, timeout_err = 0, counter = 0, latched bank/addr/data = 0; req_ready = 1 after release.
REQ-037 Reset mid-transaction SHALL abort the transaction with no response.

Structure
REQ-038 Package bm_mem_pkg SHALL hold the FSM state type and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-039 Timeout counting SHALL be a sub-module rd_timeout_counter (clear, enable, hit output).

Verification
REQ-040 write_shift_enabler = 1, write to addr 5'h03 with data 16'hABCD, mem_ready = 1 -> one-cycle mem_valid, mem_addr = 6'h23, mem_wdata = 16'hABCD.
REQ-041 read_shift_enabler = 0, read addr 5'h1F, mem_rvalid 3 cycles after issue with data 16'h1234 -> mem_addr = 6'h1F, rsp_valid one cycle, rsp_data = 16'h1234.
REQ-042 Accept write with write_shift_enabler = 0, toggle it to 1 and hold mem_ready = 0 for 4 cycles -> mem_addr stays 6'h0X (bank 0) throughout.
REQ-043 Read with TIMEOUT = 15, no mem_rvalid -> timeout_err = 1 after 16 WAIT_RD cycles, rsp_valid pulse with rsp_data = 0, next request accepted.
REQ-044 reset_n low during WAIT_RD -> no rsp_valid, req_ready = 1 after release, timeout_err = 0.
REQ-045 req_valid held high back-to-back -> req_ready low from accept until return to IDLE; no request lost or duplicated.
